div_seq: RTL and testbench

//  Sequential signed integer divider; the inverse datapath of the combinational Booth multiplier.

---
 rtl/div_seq_pkg.sv | 14 +
 rtl/div_step.sv | 27 ++
 rtl/div_seq.sv | 126 ++++++++++++
 tb/tb_div_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: controller state encoding and default width.
// The ALU control decodes the same state values.
package div_seq_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial remainder and
// subtract the divisor, keeping the difference only when it did not borrow.
module div_step
   import div_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)
(
   input  logic [WIDTH:0]   rem,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] div,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // One guard bit above the shifted remainder turns the top of diff into a clean borrow flag.
   always_comb begin
      shifted  = {rem, q_msb};
      diff     = shifted - {2'b00, div};
      q_bit    = ~diff[WIDTH+1];
      rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: magnitude restoring division over WIDTH clocks, then a sign fix-up.
// Result bus is {remainder, quotient}, matching the multiplier's {HI, LO} layout.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)
(
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic                 dz,
   output logic [2*WIDTH-1:0]   C
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q;
   logic [CW-1:0]      count_q;
   logic [WIDTH-1:0]   a_q;
   logic               sign_q_q;
   logic               dz_pend_q;
   logic [WIDTH-1:0]   div_q;
   logic [WIDTH-1:0]   q_q;
   logic [WIDTH:0]     rem_q;
   logic               busy_q;
   logic               done_q;
   logic               dz_q;
   logic [2*WIDTH-1:0] c_q;

   logic [WIDTH:0]     rem_d;
   logic               q_bit_d;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   fix_quot;
   logic [WIDTH-1:0]   fix_rem;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .q_msb    (q_q[WIDTH-1]),
      .div      (div_q),
      .rem_next (rem_d),
      .q_bit    (q_bit_d)
   );

   // Most negative operand maps to 2^(WIDTH-1), which is still exact as an unsigned magnitude.
   always_comb begin
      a_mag = A[WIDTH-1] ? -A : A;
      b_mag = B[WIDTH-1] ? -B : B;
   end

   // Remainder follows the dividend's sign; divide-by-zero yields all-ones and the dividend.
   always_comb begin
      fix_quot = sign_q_q ? -q_q : q_q;
      fix_rem  = a_q[WIDTH-1] ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      if (dz_pend_q) begin
         fix_quot = '1;
         fix_rem  = a_q;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         a_q       <= '0;
         sign_q_q  <= 1'b0;
         dz_pend_q <= 1'b0;
         div_q     <= '0;
         q_q       <= '0;
         rem_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         c_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q       <= A;
                  sign_q_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                  q_q       <= a_mag;
                  div_q     <= b_mag;
                  rem_q     <= '0;
                  count_q   <= '0;
                  dz_pend_q <= (B == '0);
                  busy_q    <= 1'b1;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               rem_q   <= rem_d;
               q_q     <= {q_q[WIDTH-2:0], q_bit_d};
               count_q <= count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               q_q     <= fix_quot;
               rem_q   <= {1'b0, fix_rem};
               state_q <= S_DONE;
            end
            S_DONE: begin
               c_q     <= {rem_q[WIDTH-1:0], q_q};
               dz_q    <= dz_pend_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;
   assign C    = c_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed and random divisions checked against a signed 64-bit model,
// plus latency, ignored start, back-to-back start and asynchronous reset abort.
module tb_div_seq;

   localparam int W   = 32;
   localparam int LAT = 34;

   logic           clk;
   logic           clr_n;
   logic           start;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic           dz;
   logic [2*W-1:0] C;

   logic [2*W:0]   exp_q[$];
   logic [2*W:0]   last_res;
   logic [2*W:0]   junk;
   logic           prev_done;
   int             n_checks;
   int             n_errors;
   int             lat;

   logic [W-1:0]   ta[8];
   logic [W-1:0]   tb_b[8];

   div_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .dz    (dz),
      .C     (C)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: truncating signed division on 64-bit values; {dz, remainder, quotient}.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      longint la, lb, q, r;
      if (b == '0) return {1'b1, a, {W{1'b1}}};
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      return {1'b0, r[W-1:0], q[W-1:0]};
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      exp_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
      check("busy_after_start", {64'd0, busy}, 65'd1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 16) check("hold_mid_run", {dz, C}, last_res);
         if (done) break;
      end
   endtask

   // Scoreboard side: every done pulse pops one expected result.
   initial begin
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (done) begin
            check("done_pulse_width", {64'd0, prev_done}, 65'd0);
            if (exp_q.size() == 0) begin
               check("done_unexpected", {64'd0, done}, 65'd0);
            end else begin
               check("result", {dz, C}, exp_q.pop_front());
            end
            last_res = {dz, C};
         end
         prev_done = done;
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      last_res = '0;
      clr_n    = 1'b0;
      start    = 1'b0;
      A        = '0;
      B        = '0;

      ta[0] = 32'd100;        tb_b[0] = 32'd7;
      ta[1] = -32'sd100;      tb_b[1] = 32'd7;
      ta[2] = 32'd100;        tb_b[2] = -32'sd7;
      ta[3] = 32'h8000_0000;  tb_b[3] = 32'hFFFF_FFFF;
      ta[4] = 32'd7;          tb_b[4] = 32'd100;
      ta[5] = 32'd5;          tb_b[5] = 32'd0;
      ta[6] = 32'h8000_0000;  tb_b[6] = 32'h8000_0000;
      ta[7] = -32'sd7;        tb_b[7] = -32'sd100;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {64'd0, busy}, 65'd0);
      check("reset_done", {64'd0, done}, 65'd0);
      check("reset_dz_c", {dz, C}, 65'd0);
      @(negedge clk);
      clr_n = 1'b1;

      // Directed operands, issued back-to-back in the cycle after each done.
      for (int i = 0; i < 8; i++) begin
         start_op(ta[i], tb_b[i]);
         wait_done(lat);
         check("latency", lat, LAT);
      end

      // A start pulse mid-run must be dropped.
      start_op(32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      A     = 32'd9;
      B     = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      check("latency_with_ignored_start", lat + 10, LAT);
      start_op(32'd9, 32'd3);
      wait_done(lat);
      check("latency_back_to_back", lat, LAT);

      // Asynchronous abort mid-run.
      start_op(32'd100, 32'd7);
      repeat (14) @(posedge clk);
      #3;
      clr_n = 1'b0;
      #1;
      check("abort_busy", {64'd0, busy}, 65'd0);
      check("abort_done", {64'd0, done}, 65'd0);
      check("abort_dz_c", {dz, C}, 65'd0);
      junk     = exp_q.pop_back();
      last_res = '0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("abort_idle_busy", {64'd0, busy}, 65'd0);
      start_op(-32'sd9, 32'd3);
      wait_done(lat);
      check("latency_after_abort", lat, LAT);

      // Random operands, with occasional zero and small divisors.
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 20));
            2:       rb = -W'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         start_op(ra, rb);
         wait_done(lat);
         check("latency_random", lat, LAT);
      end

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
